decode_stage_p: RTL and testbench

- Parametrised decode stage for the five-stage pipeline: register file, load-use hazard detection, two-word (immediate) instruction sequencing and the D/E pipeline register, all in one block.
- Sits between the F/D buffer and Execute.
- Control fields come from the existing Control_Unit.
- Execute consumes the registered D/E outputs directly.

---
 rtl/decode_stage_p_if.sv | 42 ++++
 rtl/decode_stage_p.sv | 213 +++++++++++++++++++++
 tb/tb_decode_stage_p.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_p_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_p_if
// Description : F/D buffer to decode-stage handshake bundle. Carries the
//               fetched word, the Control_Unit fields decoded from it, and
//               the stall request returned to fetch.
//   in_valid  : instr holds a valid fetched word
//   instr     : {opcode, src, dst, shiftamount} or an immediate word
//   ctrl_mem  : MEM control (bit3 = memRead)
//   ctrl_ex   : EX control
//   ctrl_wb   : WB control (bit2 = regWrite)
//   ctrl_imm  : current opcode takes a second (immediate) word
//   stall_out : freeze PC and F/D buffer
//   Modports  : master = fetch side, slave = decode stage
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_p_if #(
    parameter int W   = 16,
    parameter int N   = 3,
    parameter int OPW = 6,
    parameter int SHW = 4,
    parameter int IW  = OPW + 2*N + SHW
);
    logic          in_valid;
    logic [IW-1:0] instr;
    logic [3:0]    ctrl_mem;
    logic [5:0]    ctrl_ex;
    logic [2:0]    ctrl_wb;
    logic          ctrl_imm;
    logic          stall_out;

    modport master (
        output in_valid, instr, ctrl_mem, ctrl_ex, ctrl_wb, ctrl_imm,
        input  stall_out
    );

    modport slave (
        input  in_valid, instr, ctrl_mem, ctrl_ex, ctrl_wb, ctrl_imm,
        output stall_out
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_p
// Description : Pipeline decode stage: register file, load-use hazard
//               detection, two-word (immediate) instruction sequencing and
//               the D/E pipeline register.
//   clk, rst        : clock, synchronous active-high reset
//   fd              : F/D handshake bundle (slave modport)
//   flush_in        : branch/jump flush from Execute
//   wb_we/addr/data : register file write-back port
//   de_*            : registered D/E entry consumed by Execute
// Optional feature: define DECODE_WB_BYPASS_EN to make a same-cycle
//   write-back visible to the operand reads (write-through bypass).
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_p #(
    parameter int W   = 16,
    parameter int N   = 3,
    parameter int OPW = 6,
    parameter int SHW = 4,
    parameter int IW  = OPW + 2*N + SHW
) (
    input  wire logic           clk,
    input  wire logic           rst,
    decode_stage_p_if.slave     fd,
    input  wire logic           flush_in,
    input  wire logic           wb_we,
    input  wire logic [N-1:0]   wb_addr,
    input  wire logic [W-1:0]   wb_data,
    output logic                de_valid,
    output logic [3:0]          de_mem,
    output logic [5:0]          de_ex,
    output logic [2:0]          de_wb,
    output logic [W-1:0]        de_rsrc,
    output logic [W-1:0]        de_rdst,
    output logic [N-1:0]        de_src,
    output logic [N-1:0]        de_dst,
    output logic [SHW-1:0]      de_sham,
    output logic [W-1:0]        de_imm
);

    localparam int NREG = 1 << N;

    if (IW > W) begin : g_bad_iw
        $error("decode_stage_p: IW must not exceed W");
    end

    typedef enum logic [0:0] {
        S_DEC = 1'b0,
        S_IMM = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [W-1:0]   r_regs [NREG];

    // First word of a two-word instruction. The opcode itself is not kept:
    // its only consumer is Control_Unit, whose decoded fields are held here.
    logic [3:0]     r_hold_mem;
    logic [5:0]     r_hold_ex;
    logic [2:0]     r_hold_wb;
    logic [N-1:0]   r_hold_src;
    logic [N-1:0]   r_hold_dst;
    logic [SHW-1:0] r_hold_sham;

    logic [N-1:0]   w_live_src;
    logic [N-1:0]   w_live_dst;
    logic [SHW-1:0] w_live_sham;

    logic [N-1:0]   w_src_a;
    logic [N-1:0]   w_dst_a;
    logic [W-1:0]   w_rsrc;
    logic [W-1:0]   w_rdst;
    logic           w_hz;

    logic           w_load_entry;
    logic           w_capture;
    logic           w_stall;

    assign w_live_src  = fd.instr[2*N+SHW-1 -: N];
    assign w_live_dst  = fd.instr[N+SHW-1 -: N];
    assign w_live_sham = fd.instr[SHW-1:0];

    // In S_IMM the live word is an immediate, so addresses come from hold.
    assign w_src_a = (r_state == S_IMM) ? r_hold_src : w_live_src;
    assign w_dst_a = (r_state == S_IMM) ? r_hold_dst : w_live_dst;

`ifdef DECODE_WB_BYPASS_EN
    assign w_rsrc = (wb_we && (wb_addr == w_src_a)) ? wb_data : r_regs[w_src_a];
    assign w_rdst = (wb_we && (wb_addr == w_dst_a)) ? wb_data : r_regs[w_dst_a];
`else
    assign w_rsrc = r_regs[w_src_a];
    assign w_rdst = r_regs[w_dst_a];
`endif

    // Load in D/E whose result is needed by the instruction being decoded.
    assign w_hz = de_valid & de_mem[3] & de_wb[2] &
                  ((de_dst == w_src_a) | (de_dst == w_dst_a));

    // ------------------------------------------------------------------
    // FSM next state and load decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_load_entry = 1'b0;
        w_capture    = 1'b0;
        w_stall      = 1'b0;
        if (flush_in) begin
            w_state_nxt = S_DEC;
        end else if (fd.in_valid) begin
            if (w_hz) begin
                w_stall = 1'b1;
            end else if (r_state == S_DEC) begin
                if (fd.ctrl_imm) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IMM;
                end else begin
                    w_load_entry = 1'b1;
                end
            end else begin
                w_load_entry = 1'b1;
                w_state_nxt  = S_DEC;
            end
        end
    end

    assign fd.stall_out = w_stall & ~rst;

    // ------------------------------------------------------------------
    // FSM state and hold register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_DEC;
            r_hold_mem  <= '0;
            r_hold_ex   <= '0;
            r_hold_wb   <= '0;
            r_hold_src  <= '0;
            r_hold_dst  <= '0;
            r_hold_sham <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush_in) begin
                r_hold_mem  <= '0;
                r_hold_ex   <= '0;
                r_hold_wb   <= '0;
                r_hold_src  <= '0;
                r_hold_dst  <= '0;
                r_hold_sham <= '0;
            end else if (w_capture) begin
                r_hold_mem  <= fd.ctrl_mem;
                r_hold_ex   <= fd.ctrl_ex;
                r_hold_wb   <= fd.ctrl_wb;
                r_hold_src  <= w_live_src;
                r_hold_dst  <= w_live_dst;
                r_hold_sham <= w_live_sham;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file: write-back always commits, independent of stall/flush
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // D/E pipeline register: anything other than an entry load is a bubble
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || !w_load_entry) begin
            de_valid <= 1'b0;
            de_mem   <= '0;
            de_ex    <= '0;
            de_wb    <= '0;
            de_rsrc  <= '0;
            de_rdst  <= '0;
            de_src   <= '0;
            de_dst   <= '0;
            de_sham  <= '0;
            de_imm   <= '0;
        end else begin
            de_valid <= 1'b1;
            de_rsrc  <= w_rsrc;
            de_rdst  <= w_rdst;
            de_src   <= w_src_a;
            de_dst   <= w_dst_a;
            if (r_state == S_IMM) begin
                de_mem  <= r_hold_mem;
                de_ex   <= r_hold_ex;
                de_wb   <= r_hold_wb;
                de_sham <= r_hold_sham;
                de_imm  <= W'(fd.instr);
            end else begin
                de_mem  <= fd.ctrl_mem;
                de_ex   <= fd.ctrl_ex;
                de_wb   <= fd.ctrl_wb;
                de_sham <= w_live_sham;
                de_imm  <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage_p
// Description : Directed self-checking bench for decode_stage_p.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_p;

    localparam int W   = 16;
    localparam int N   = 3;
    localparam int OPW = 6;
    localparam int SHW = 4;
    localparam int IW  = OPW + 2*N + SHW;

    logic           clk;
    logic           rst;
    logic           flush_in;
    logic           wb_we;
    logic [N-1:0]   wb_addr;
    logic [W-1:0]   wb_data;
    logic           de_valid;
    logic [3:0]     de_mem;
    logic [5:0]     de_ex;
    logic [2:0]     de_wb;
    logic [W-1:0]   de_rsrc;
    logic [W-1:0]   de_rdst;
    logic [N-1:0]   de_src;
    logic [N-1:0]   de_dst;
    logic [SHW-1:0] de_sham;
    logic [W-1:0]   de_imm;

    int n_assert;
    int n_fail;

    decode_stage_p_if #(.W(W), .N(N), .OPW(OPW), .SHW(SHW), .IW(IW)) fd_if ();

    decode_stage_p #(.W(W), .N(N), .OPW(OPW), .SHW(SHW), .IW(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .fd       (fd_if.slave),
        .flush_in (flush_in),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .de_valid (de_valid),
        .de_mem   (de_mem),
        .de_ex    (de_ex),
        .de_wb    (de_wb),
        .de_rsrc  (de_rsrc),
        .de_rdst  (de_rdst),
        .de_src   (de_src),
        .de_dst   (de_dst),
        .de_sham  (de_sham),
        .de_imm   (de_imm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [IW-1:0] mk(input logic [OPW-1:0] op, input logic [N-1:0] s,
                                         input logic [N-1:0] d, input logic [SHW-1:0] sh);
        return {op, s, d, sh};
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] ins, input logic [3:0] m,
                         input logic [5:0] e, input logic [2:0] w, input logic imm);
        fd_if.in_valid = v;
        fd_if.instr    = ins;
        fd_if.ctrl_mem = m;
        fd_if.ctrl_ex  = e;
        fd_if.ctrl_wb  = w;
        fd_if.ctrl_imm = imm;
    endtask

    function automatic logic [79:0] de_all();
        return 80'({de_valid, de_mem, de_ex, de_wb, de_rsrc, de_rdst,
                    de_src, de_dst, de_sham, de_imm});
    endfunction

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        flush_in = 1'b0;
        wb_we    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        drive(1'b0, '0, 4'h0, 6'h00, 3'h0, 1'b0);

        // Reset
        tick();
        tick();
        chk("reset_de_all", de_all(), 80'h0);
        chk("reset_stall", 80'(fd_if.stall_out), 80'h0);
        rst = 1'b0;

        // Write r3 = BEEF, no decode
        wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'hBEEF;
        tick();
        chk("idle_bubble", 80'(de_valid), 80'h0);

        // Decode src=3 dst=0
        wb_we = 1'b0;
        drive(1'b1, mk(6'h01, 3'd3, 3'd0, 4'h7), 4'h0, 6'h15, 3'b001, 1'b0);
        tick();
        chk("rd_valid", 80'(de_valid), 80'h1);
        chk("rd_rsrc",  80'(de_rsrc),  80'hBEEF);
        chk("rd_rdst",  80'(de_rdst),  80'h0);
        chk("rd_fields", 80'({de_src, de_dst, de_sham, de_ex, de_wb, de_imm}),
            80'({3'd3, 3'd0, 4'h7, 6'h15, 3'b001, 16'h0}));

        // Same-cycle write-back r5 = 1234 while decoding src=5 dst=3
        wb_we = 1'b1; wb_addr = 3'd5; wb_data = 16'h1234;
        drive(1'b1, mk(6'h02, 3'd5, 3'd3, 4'h0), 4'h0, 6'h01, 3'b001, 1'b0);
        #1;
        chk("wb_nostall", 80'(fd_if.stall_out), 80'h0);
        tick();
`ifdef DECODE_WB_BYPASS_EN
        chk("wb_same_cycle_rsrc", 80'(de_rsrc), 80'h1234);
`else
        chk("wb_same_cycle_rsrc", 80'(de_rsrc), 80'h0);
`endif
        chk("wb_same_cycle_rdst", 80'(de_rdst), 80'hBEEF);

        // Load: memRead + regWrite, dst=2, src=5 (write now committed)
        wb_we = 1'b0;
        drive(1'b1, mk(6'h03, 3'd5, 3'd2, 4'h0), 4'b1000, 6'h00, 3'b100, 1'b0);
        tick();
        chk("load_entry", 80'({de_valid, de_mem, de_wb, de_dst, de_rsrc}),
            80'({1'b1, 4'b1000, 3'b100, 3'd2, 16'h1234}));

        // Dependent instruction src=2: one stall cycle, one bubble
        drive(1'b1, mk(6'h04, 3'd2, 3'd1, 4'h3), 4'h0, 6'h07, 3'b001, 1'b0);
        #1;
        chk("hz_stall", 80'(fd_if.stall_out), 80'h1);
        tick();
        chk("hz_bubble", 80'({de_valid, de_mem, de_wb}), 80'h0);
        chk("hz_stall_released", 80'(fd_if.stall_out), 80'h0);
        tick();
        chk("hz_after", 80'({de_valid, de_src, de_dst, de_sham, de_ex}),
            80'({1'b1, 3'd2, 3'd1, 4'h3, 6'h07}));

        // Two-word instruction, idle cycle, then immediate 0x00A5
        drive(1'b1, mk(6'h05, 3'd1, 3'd3, 4'h2), 4'h0, 6'h2A, 3'b100, 1'b1);
        tick();
        chk("imm_first_bubble", 80'(de_valid), 80'h0);
        drive(1'b0, mk(6'h3F, 3'd7, 3'd7, 4'hF), 4'h0, 6'h00, 3'b000, 1'b0);
        tick();
        chk("imm_idle_bubble", 80'(de_valid), 80'h0);
        drive(1'b1, 16'h00A5, 4'h0, 6'h00, 3'b000, 1'b0);
        tick();
        chk("imm_entry", de_all(),
            80'({1'b1, 4'h0, 6'h2A, 3'b100, 16'h0, 16'hBEEF, 3'd1, 3'd3, 4'h2, 16'h00A5}));

        // Flush while in S_IMM
        drive(1'b1, mk(6'h06, 3'd4, 3'd4, 4'h1), 4'h0, 6'h11, 3'b001, 1'b1);
        tick();
        flush_in = 1'b1;
        drive(1'b1, 16'h5555, 4'h0, 6'h00, 3'b000, 1'b0);
        tick();
        chk("flush_bubble", 80'(de_valid), 80'h0);
        flush_in = 1'b0;
        drive(1'b1, mk(6'h07, 3'd3, 3'd5, 4'h0), 4'h0, 6'h01, 3'b001, 1'b0);
        tick();
        chk("flush_fresh", 80'({de_valid, de_src, de_dst, de_ex, de_rsrc, de_rdst, de_imm}),
            80'({1'b1, 3'd3, 3'd5, 6'h01, 16'hBEEF, 16'h1234, 16'h0}));

        // Flush overrides a load-use hazard
        drive(1'b1, mk(6'h08, 3'd0, 3'd6, 4'h0), 4'b1000, 6'h00, 3'b100, 1'b0);
        tick();
        flush_in = 1'b1;
        drive(1'b1, mk(6'h09, 3'd6, 3'd1, 4'h0), 4'h0, 6'h01, 3'b001, 1'b0);
        #1;
        chk("flush_hz_nostall", 80'(fd_if.stall_out), 80'h0);
        tick();
        chk("flush_hz_bubble", 80'(de_valid), 80'h0);
        flush_in = 1'b0;

        // Reset while a load is in D/E and a dependent two-word first word waits
        drive(1'b1, mk(6'h0A, 3'd0, 3'd3, 4'h0), 4'b1000, 6'h00, 3'b100, 1'b0);
        tick();
        chk("pre_rst_valid", 80'(de_valid), 80'h1);
        rst = 1'b1;
        drive(1'b1, mk(6'h0B, 3'd3, 3'd4, 4'h0), 4'h0, 6'h22, 3'b001, 1'b1);
        #1;
        chk("rst_nostall", 80'(fd_if.stall_out), 80'h0);
        tick();
        chk("rst_de_all", de_all(), 80'h0);
        rst = 1'b0;
        drive(1'b1, mk(6'h0C, 3'd3, 3'd5, 4'h0), 4'h0, 6'h01, 3'b001, 1'b0);
        tick();
        chk("rst_regs_cleared", 80'({de_valid, de_rsrc, de_rdst, de_imm}),
            80'({1'b1, 16'h0, 16'h0, 16'h0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
